// File: rtl/mux4x1_using2x1.sv
// 4:1 select primitive built as a two-level tree of 2:1 leaf cells,
// with a combinational output and a registered copy of output and select.

module mux2x1 #(
    parameter int WIDTH = 1
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sel,
    output logic [WIDTH-1:0] o
);

    assign o = sel ? b : a;

endmodule

module mux4x1_using2x1 #(
    parameter int WIDTH = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [4*WIDTH-1:0] i,
    input  logic [1:0]         s,
    output logic [WIDTH-1:0]   y,
    output logic [WIDTH-1:0]   y_q,
    output logic [1:0]         s_q
);

    logic [WIDTH-1:0] m0;
    logic [WIDTH-1:0] m1;

    // Leaf stage: s[0] picks within each lane pair.
    mux2x1 #(.WIDTH(WIDTH)) u_leaf0 (
        .a   (i[0*WIDTH +: WIDTH]),
        .b   (i[1*WIDTH +: WIDTH]),
        .sel (s[0]),
        .o   (m0)
    );

    mux2x1 #(.WIDTH(WIDTH)) u_leaf1 (
        .a   (i[2*WIDTH +: WIDTH]),
        .b   (i[3*WIDTH +: WIDTH]),
        .sel (s[0]),
        .o   (m1)
    );

    // Root stage: s[1] picks between the two pairs.
    mux2x1 #(.WIDTH(WIDTH)) u_root (
        .a   (m0),
        .b   (m1),
        .sel (s[1]),
        .o   (y)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_q <= '0;
            s_q <= 2'b00;
        end else begin
            y_q <= y;
            s_q <= s;
        end
    end

endmodule

// File: tb/tb_mux4x1_using2x1.sv
// Directed bench for mux4x1_using2x1 at WIDTH=1 and WIDTH=8, with a
// queue-based scoreboard for the registered outputs.

module tb_mux4x1_using2x1;

    logic        clk;
    logic        rst;
    logic [3:0]  i1;
    logic [1:0]  s1;
    logic [0:0]  y1;
    logic [0:0]  y_q1;
    logic [1:0]  s_q1;
    logic [31:0] i8;
    logic [1:0]  s8;
    logic [7:0]  y8;
    logic [7:0]  y_q8;
    logic [1:0]  s_q8;

    int n_tests = 0;
    int n_fail  = 0;

    logic [2:0] exp_q1[$];
    logic [9:0] exp_q8[$];

    mux4x1_using2x1 #(.WIDTH(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .i   (i1),
        .s   (s1),
        .y   (y1),
        .y_q (y_q1),
        .s_q (s_q1)
    );

    mux4x1_using2x1 #(.WIDTH(8)) dut8 (
        .clk (clk),
        .rst (rst),
        .i   (i8),
        .s   (s8),
        .y   (y8),
        .y_q (y_q8),
        .s_q (s_q8)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic model1(input logic [3:0] v, input logic [1:0] sel);
        case (sel)
            2'b00:   return v[0];
            2'b01:   return v[1];
            2'b10:   return v[2];
            default: return v[3];
        endcase
    endfunction

    function automatic logic [7:0] model8(input logic [31:0] v, input logic [1:0] sel);
        case (sel)
            2'b00:   return v[7:0];
            2'b01:   return v[15:8];
            2'b10:   return v[23:16];
            default: return v[31:24];
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // driver + scoreboard, WIDTH=1: drive after a falling edge, check y,
    // then compare the registered outputs one rising edge later
    task automatic apply1(input string tag, input logic [3:0] iv, input logic [1:0] sv);
        logic [2:0] e;
        @(negedge clk);
        i1 = iv;
        s1 = sv;
        #1;
        chk({tag, ".y"}, 32'(y1), 32'(model1(iv, sv)));
        exp_q1.push_back({sv, model1(iv, sv)});
        @(posedge clk);
        #1;
        e = exp_q1.pop_front();
        chk({tag, ".y_q"}, 32'(y_q1), 32'(e[0]));
        chk({tag, ".s_q"}, 32'(s_q1), 32'(e[2:1]));
    endtask

    task automatic apply8(input string tag, input logic [31:0] iv, input logic [1:0] sv);
        logic [9:0] e;
        @(negedge clk);
        i8 = iv;
        s8 = sv;
        #1;
        chk({tag, ".y"}, 32'(y8), 32'(model8(iv, sv)));
        exp_q8.push_back({sv, model8(iv, sv)});
        @(posedge clk);
        #1;
        e = exp_q8.pop_front();
        chk({tag, ".y_q"}, 32'(y_q8), 32'(e[7:0]));
        chk({tag, ".s_q"}, 32'(s_q8), 32'(e[9:8]));
    endtask

    initial begin
        logic [2:0]  e1;
        logic [9:0]  e8;
        int          tt;

        rst = 1'b1;
        i1  = 4'b0000;
        s1  = 2'b00;
        i8  = 32'h0;
        s8  = 2'b00;

        // reset state, and y tracks inputs during reset
        #2;
        chk("rst.y_q1", 32'(y_q1), 32'd0);
        chk("rst.s_q1", 32'(s_q1), 32'd0);
        chk("rst.y_q8", 32'(y_q8), 32'd0);
        i1 = 4'b1000;
        s1 = 2'b11;
        #1;
        chk("rst.y_tracks", 32'(y1), 32'd1);
        @(posedge clk);
        #1;
        chk("rst.hold_y_q1", 32'(y_q1), 32'd0);
        chk("rst.hold_s_q1", 32'(s_q1), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // static select sweep
        apply1("sweep00", 4'b1010, 2'b00);
        apply1("sweep01", 4'b1010, 2'b01);
        apply1("sweep10", 4'b1010, 2'b10);
        apply1("sweep11", 4'b1010, 2'b11);

        // unselected-lane isolation
        apply1("iso_setup", 4'b0100, 2'b10);
        for (int k = 0; k < 10; k++) begin
            #4;
            i1 = i1 ^ 4'b1011;
            #1;
            chk("iso.y", 32'(y1), 32'd1);
            chk("iso.y_q", 32'(y_q1), 32'd1);
        end

        // free-running pattern against the reference model
        for (int k = 0; k < 40; k++) begin
            tt = k * 5;
            i1 = {1'((tt / 5) % 2), 1'((tt / 10) % 2), 1'((tt / 15) % 2), 1'((tt / 20) % 2)};
            s1 = {1'((tt / 5) % 2), 1'((tt / 10) % 2)};
            #2;
            chk("free.y", 32'(y1), 32'(model1(i1, s1)));
            #3;
        end

        // asynchronous reset between edges
        apply1("arst_setup", 4'b0010, 2'b01);
        #3;
        rst = 1'b1;
        #1;
        chk("arst.y_q", 32'(y_q1), 32'd0);
        chk("arst.s_q", 32'(s_q1), 32'd0);
        chk("arst.y", 32'(y1), 32'd1);
        @(posedge clk);
        #1;
        chk("arst.held", 32'(y_q1), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("arst.no_edge", 32'(y_q1), 32'd0);
        @(posedge clk);
        #1;
        chk("arst.reload_y_q", 32'(y_q1), 32'd1);
        chk("arst.reload_s_q", 32'(s_q1), 32'd1);

        // wide lanes
        apply8("wide11", 32'h44332211, 2'b11);
        apply8("wide01", 32'h44332211, 2'b01);
        for (int k = 0; k < 6; k++) begin
            apply8("wide_rand",
                   {8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                    8'($urandom_range(0, 255)), 8'($urandom_range(0, 255))},
                   2'($urandom_range(0, 3)));
        end

        // simultaneous i/s change 1 ns before a rising edge
        apply1("simul_setup", 4'b0010, 2'b01);
        apply8("simul_setup8", 32'h44332211, 2'b00);
        @(posedge clk);
        #9;
        i1 = 4'b1011;
        s1 = 2'b10;
        i8 = 32'hA5C3_5A3C;
        s8 = 2'b10;
        exp_q1.push_back({2'b10, model1(4'b1011, 2'b10)});
        exp_q8.push_back({2'b10, model8(32'hA5C3_5A3C, 2'b10)});
        @(posedge clk);
        #1;
        e1 = exp_q1.pop_front();
        e8 = exp_q8.pop_front();
        chk("simul.y_q1", 32'(y_q1), 32'(e1[0]));
        chk("simul.s_q1", 32'(s_q1), 32'(e1[2:1]));
        chk("simul.y_q8", 32'(y_q8), 32'(e8[7:0]));
        chk("simul.s_q8", 32'(s_q8), 32'(e8[9:8]));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
